// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GAP       = 2'd1,
    SHOW      = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Correct hits per speed-up step.
  localparam int SPEEDUP_GROUP = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one clock out of every TICK_DIV.
// First tick appears during the TICK_DIV-th clock after reset release.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(TICK_DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

endmodule

// File: rtl/whack_mole_scheduler.sv
// Round sequencer: ticks, random mole selection, hit judging; all outputs registered,
// inputs edge-detected after one register stage. WHACK_SPEEDUP_EN shortens the show time as hits accrue.
module whack_mole_scheduler
  import whack_pkg::*;
#(
  parameter int N_HOLES        = 8,
  parameter int TICK_DIV       = 50_000_000,
  parameter int SHOW_TICKS     = 3,
  parameter int GAP_TICKS      = 1,
  parameter int ROUND_TICKS    = 60,
  parameter int MIN_SHOW_TICKS = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_HOLES-1:0] hit,
  output logic [N_HOLES-1:0] mole,
  output logic               score_inc,
  output logic               miss_inc,
  output logic               score_clr,
  output logic               busy,
  output logic               game_over
);

  localparam int HW     = $clog2(N_HOLES);
  localparam int RW     = $clog2(ROUND_TICKS + 1);
  localparam int PH_A   = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int PH_MAX = (PH_A > MIN_SHOW_TICKS) ? PH_A : MIN_SHOW_TICKS;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam logic [N_HOLES-1:0] ONE_HOT0 = N_HOLES'(1);

  logic               tick;
  logic               start_s1_q, start_s2_q;
  logic [N_HOLES-1:0] hit_s1_q, hit_s2_q;
  logic [15:0]        lfsr_q;
  state_t             state_q;
  logic [RW-1:0]      round_q;
  logic [PW-1:0]      phase_q;
  logic [HW-1:0]      hole_q;
  logic [N_HOLES-1:0] mole_q;
  logic               score_inc_q, miss_inc_q, score_clr_q, busy_q, game_over_q;

  logic               start_edge, round_start, in_play;
  logic [N_HOLES-1:0] hit_edge, lit_mask;
  logic               hit_ok, hit_bad, phase_exp, round_exp;
  logic [HW-1:0]      candidate, next_hole;
  logic [PW-1:0]      show_len;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock  (clock),
    .reset_n(reset_n),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      hit_s1_q   <= '0;
      hit_s2_q   <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      start_s1_q <= start;
      start_s2_q <= start_s1_q;
      hit_s1_q   <= hit;
      hit_s2_q   <= hit_s1_q;
      lfsr_q     <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign start_edge  = start_s1_q & ~start_s2_q;
  assign hit_edge    = hit_s1_q & ~hit_s2_q;
  assign round_start = start_edge & ((state_q == IDLE) | (state_q == GAME_OVER));
  assign in_play     = (state_q == GAP) | (state_q == SHOW);
  assign lit_mask    = ONE_HOT0 << hole_q;
  assign hit_ok      = |(hit_edge & lit_mask);
  assign hit_bad     = |(hit_edge & ~lit_mask);
  assign phase_exp   = tick & (phase_q == PW'(1));
  assign round_exp   = tick & (round_q == RW'(1));
  // Never light the same hole twice running; power-of-two count makes +1 wrap for free.
  assign candidate   = lfsr_q[HW-1:0];
  assign next_hole   = (candidate == hole_q) ? candidate + HW'(1) : candidate;

`ifdef WHACK_SPEEDUP_EN
  localparam int GW = $clog2(SPEEDUP_GROUP);

  logic [PW-1:0] show_len_q;
  logic [GW-1:0] grp_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      show_len_q <= PW'(SHOW_TICKS);
      grp_q      <= '0;
    end else if (round_start) begin
      show_len_q <= PW'(SHOW_TICKS);
      grp_q      <= '0;
    end else if (state_q == SHOW && hit_ok) begin
      if (grp_q == GW'(SPEEDUP_GROUP - 1)) begin
        grp_q <= '0;
        if (show_len_q > PW'(MIN_SHOW_TICKS)) show_len_q <= show_len_q - PW'(1);
      end else begin
        grp_q <= grp_q + GW'(1);
      end
    end
  end

  assign show_len = show_len_q;
`else
  assign show_len = PW'(SHOW_TICKS);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      round_q     <= '0;
      phase_q     <= '0;
      hole_q      <= '0;
      mole_q      <= '0;
      score_inc_q <= 1'b0;
      miss_inc_q  <= 1'b0;
      score_clr_q <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      score_inc_q <= 1'b0;
      miss_inc_q  <= 1'b0;
      score_clr_q <= 1'b0;
      if (tick && in_play) round_q <= round_q - RW'(1);

      case (state_q)
        IDLE, GAME_OVER: begin
          if (start_edge) begin
            score_clr_q <= 1'b1;
            round_q     <= RW'(ROUND_TICKS);
            phase_q     <= PW'(GAP_TICKS);
            busy_q      <= 1'b1;
            game_over_q <= 1'b0;
            state_q     <= GAP;
          end
        end
        GAP: begin
          if (tick) phase_q <= phase_q - PW'(1);
          if (phase_exp) begin
            hole_q  <= next_hole;
            mole_q  <= ONE_HOT0 << next_hole;
            phase_q <= show_len;
            state_q <= SHOW;
          end
        end
        SHOW: begin
          if (tick) phase_q <= phase_q - PW'(1);
          if (hit_ok) begin
            score_inc_q <= 1'b1;
            mole_q      <= '0;
            phase_q     <= PW'(GAP_TICKS);
            state_q     <= GAP;
          end else if (phase_exp) begin
            miss_inc_q <= 1'b1;
            mole_q     <= '0;
            phase_q    <= PW'(GAP_TICKS);
            state_q    <= GAP;
          end else if (hit_bad) begin
            miss_inc_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // End of round wins over any phase move, but pulses issued above still go out.
      if (round_exp && in_play) begin
        state_q     <= GAME_OVER;
        mole_q      <= '0;
        busy_q      <= 1'b0;
        game_over_q <= 1'b1;
      end
    end
  end

  assign mole      = mole_q;
  assign score_inc = score_inc_q;
  assign miss_inc  = miss_inc_q;
  assign score_clr = score_clr_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;

endmodule
